// File: rtl/bus_pkg.sv
// Shared definitions for the bus transmit arbiter: FSM states, header layout, Gray map.
package bus_pkg;
  localparam int SRC_ID_W     = 2;
  localparam int DEST_W       = 2;
  localparam int HDR_DEST_LSB = 6;  // header bits [7:6]
  localparam int HDR_SRC_LSB  = 4;  // header bits [5:4]; [3:0] reserved, always zero

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Binary to reflected Gray: 0->00, 1->01, 2->11, 3->10
  function automatic logic [DEST_W-1:0] gray_map(input logic [DEST_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request strictly after ptr_i, wrapping.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [SRC_ID_W-1:0]   ptr_i,
  output logic [N-1:0]          gnt_o,
  output logic [SRC_ID_W-1:0]   idx_o,
  output logic                  any_o
);

  // Walk the N candidates in rotated order and take the first requester
  always_comb begin
    logic [SRC_ID_W-1:0] c;
    logic                found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = ptr_i;
    for (int k = 0; k < N; k++) begin
      c = (c == SRC_ID_W'(N - 1)) ? '0 : c + SRC_ID_W'(1);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/bus_tx_arbiter.sv
// Bus transmit arbiter: round-robin grant, Gray-coded header beat, then
// zero-latency passthrough of the winner until last, beat limit or stall timeout.
module bus_tx_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BEATS = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  input  logic [2*NUM_SRC-1:0]   src_dest,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic [NUM_SRC-1:0]     ack,
  output logic                   bus_valid,
  output logic [7:0]             bus_data,
  output logic                   bus_last,
  input  logic                   bus_ready,
  output logic                   xfer_abort
);

  localparam int BEAT_W  = $clog2(MAX_BEATS + 1);
  localparam int STALL_W = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [SRC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_ID_W-1:0] gnt_q, gnt_d;
  logic [NUM_SRC-1:0]  ack_q, ack_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic [NUM_SRC-1:0]  arb_gnt;
  logic [SRC_ID_W-1:0] arb_idx;
  logic                arb_any;

  logic                g_valid, g_last;
  logic [7:0]          g_data;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req_i (src_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign g_valid = src_valid[gnt_q];
  assign g_last  = src_last[gnt_q];
  assign g_data  = src_data[int'(gnt_q)*8 +: 8];
  assign ack     = ack_q;

  // Next-state and bus outputs; everything idles to zero outside HDR/DATA
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    ack_d      = ack_q;
    dest_d     = dest_q;
    beat_d     = beat_q;
    stall_d    = stall_q;
    src_ready  = '0;
    bus_valid  = 1'b0;
    bus_data   = '0;
    bus_last   = 1'b0;
    xfer_abort = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          ack_d   = arb_gnt;
          dest_d  = src_dest[int'(arb_idx)*2 +: 2];
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        // Header is committed once granted, independent of the source's valid
        bus_valid = 1'b1;
        bus_data[HDR_DEST_LSB +: DEST_W]  = gray_map(dest_q);
        bus_data[HDR_SRC_LSB +: SRC_ID_W] = gnt_q;
        if (bus_ready) begin
          beat_d  = '0;
          stall_d = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        bus_valid        = g_valid;
        bus_data         = g_valid ? g_data : 8'h00;
        src_ready[gnt_q] = bus_ready;
        bus_last         = g_valid & (g_last | (beat_q == BEAT_W'(MAX_BEATS - 1)));
        if (g_valid) begin
          stall_d = '0;
          if (bus_ready) begin
            beat_d = beat_q + BEAT_W'(1);
            if (bus_last) begin
              state_d  = ST_IDLE;
              rr_ptr_d = gnt_q;
              ack_d    = '0;
            end
          end
        end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          // Stalled source: drop the frame without a last beat
          xfer_abort = 1'b1;
          state_d    = ST_IDLE;
          rr_ptr_d   = gnt_q;
          ack_d      = '0;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; rr_ptr resets to the last source so source 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= SRC_ID_W'(NUM_SRC - 1);
      gnt_q    <= '0;
      ack_q    <= '0;
      dest_q   <= '0;
      beat_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      dest_q   <= dest_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: doc/bus_tx_arbiter.md
Name: bus_tx_arbiter

Overview:
- Upstream stage of the shared 8-bit data bus: arbitrates among NUM_SRC transmitting modules and issues a one-hot ACK (grant) to the winner.
- Emits a header beat carrying the Gray-mapped destination ID in bits [7:6], then passes the winner's data stream onto the bus using valid/ready.
- Releases the bus on last, after a beat limit, or on a stall timeout.

Parameters:
- NUM_SRC, 4: number of requesting sources (2..4); source ID width is 2.
- MAX_BEATS, 16: maximum data beats per grant (excluding header).
- TIMEOUT, 32: consecutive cycles of src_valid low in DATA that cause an abort.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source data valid / bus request.
- src_data  in  8*NUM_SRC  per-source byte; source i at [8i+7:8i].
- src_last  in  NUM_SRC  per-source end-of-packet marker.
- src_dest  in  2*NUM_SRC  per-source binary destination ID; source i at [2i+1:2i].
- src_ready  out  NUM_SRC  per-source accept strobe.
- ack  out  NUM_SRC  one-hot grant, held for the whole transfer.
- bus_valid  out  1  bus beat valid.
- bus_data  out  8  bus byte.
- bus_last  out  1  final beat of the transfer.
- bus_ready  in  1  downstream accept.
- xfer_abort  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (asynchronous, any cycle including mid-transfer):
  - state=IDLE; ack=0, src_ready=0, bus_valid=0, bus_data=0, bus_last=0, xfer_abort=0.
  - rr_ptr=NUM_SRC-1, so source 0 has first priority; beat_cnt=0, stall_cnt=0.
- IDLE:
  - ack=0; outputs 0.
  - If any src_valid is high at posedge N, the winner is the first set bit searching upward from rr_ptr+1 with wrap.
  - Winner index and src_dest[winner] are registered; state=HDR. ack[winner] is high from cycle N+1.
- HDR:
  - bus_valid=1; bus_data={gray(dest), src_id[1:0], 4'b0000}; bus_last=0; all src_ready=0.
  - Gray map: 0→00, 1→01, 2→11, 3→10.
  - Header is committed: if the winner drops src_valid, the header is still sent.
  - On bus_ready: beat_cnt=0, state=DATA.
- DATA (combinational passthrough of the granted source, zero latency):
  - bus_valid=src_valid[g]; bus_data=src_data[g] (0 when not valid).
  - src_ready[g]=bus_ready; all other src_ready=0.
  - bus_last=src_valid[g] & (src_last[g] | beat_cnt==MAX_BEATS-1).
  - Each handshake (bus_valid & bus_ready) increments beat_cnt.
  - Handshake with bus_last=1: rr_ptr=g, state=IDLE; ack drops the next cycle.
  - Beat-limit cut: the source sees ack fall and must re-request for the remainder of its packet.
  - stall_cnt increments while src_valid[g]=0 and clears on src_valid[g]=1.
  - stall_cnt reaching TIMEOUT-1 with valid still low: xfer_abort=1 for one cycle, rr_ptr=g, state=IDLE. No bus_last is emitted; the downstream discards the partial frame.
- Minimum one IDLE cycle between grants. A request present in the last DATA cycle is evaluated in IDLE.
- A request changing while the source is not granted has no effect until IDLE sampling.
- Invariants:
  - ack is one-hot or zero.
  - src_ready is never high for a non-granted source.
  - bus_valid is never high in IDLE.

Decomposition:
- bus_pkg:
  - state encoding (IDLE, HDR, DATA).
  - gray_map function.
  - header field positions: DEST [7:6], SRC [5:4], RSVD [3:0].
  - SRC_ID_W=2.
- Sub-module rr_arbiter:
  - inputs: req vector, rr_ptr.
  - outputs: one-hot grant and encoded index.
  - purely combinational priority rotate; the pointer register stays in the parent.

Test Plan:
1. Single source 1, dest=2, 3 bytes 0xA1,0xA2,0xA3 (last on 3rd), bus_ready=1 → ack=0010 one cycle after request; bus beats 0xD0, 0xA1, 0xA2, 0xA3 (bus_last on 0xA3); ack=0 the next cycle.
2. Sources 0 and 2 request simultaneously from reset, each sending 1-byte packets, repeating → grants alternate 0,2,0,2; header SRC field matches each grant; one IDLE bubble between grants.
3. Source 3 streams 20 bytes without last, MAX_BEATS=16 → header plus 16 data beats, bus_last on beat 16; ack drops; re-grant to source 3; second header, then 4 beats.
4. Backpressure: bus_ready low for 3 cycles during HDR and for 2 cycles mid-DATA → bus_data/bus_valid held stable; src_ready[g]=0 while bus_ready=0; no beat lost or duplicated.
5. Granted source 0 drops src_valid for 32 cycles after one data beat → xfer_abort pulse in exactly one cycle; state IDLE; next arbitration starts from source 1.
6. Assert reset during DATA beat 5 → all outputs 0 asynchronously (before the next clk edge); after release, source 0 has priority over a simultaneous source 3 request.
